result_streamer: RTL and testbench

Buffers the n×n result matrix produced by the multiplier array and streams it, one 32-bit element at a time in row-major order, to the downstream file-writer stage over a strobe/acknowledge handshake. It sits between the multiplier's result write port and the writer. The writer consumes `value` together with the current row index `i` and column index `j`.

---
 rtl/matmul_pkg.sv | 19 +
 rtl/result_ram.sv | 42 ++++
 rtl/result_streamer.sv | 154 +++++++++++++++
 tb/tb_result_streamer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types and constants for the matrix-multiply result path:
// streamer state encoding, data width and index-width helper.
package matmul_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_LOAD   = 3'd2,
        ST_STREAM = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    function automatic int calc_n_len(input int dim);
        return $clog2(dim);
    endfunction

endpackage

// File: rtl/result_ram.sv
// One-write/one-read result buffer with a registered read port; the read
// register only updates when re is high, so it can serve as a held output.
module result_ram
    import matmul_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              re,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rd_data_r;

    // Storage array: no reset, contents are only meaningful after a fill
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Synchronous read register, cleared by reset and held while re is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r <= '0;
        end else if (re) begin
            rd_data_r <= mem_r[rd_addr];
        end else begin
            rd_data_r <= rd_data_r;
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/result_streamer.sv
// Collects the n x n result matrix in any write order, then streams it
// row-major to the file writer over a strobe/acknowledge handshake.
module result_streamer
    import matmul_pkg::*;
#(
    parameter int n     = 8,
    parameter int n_len = calc_n_len(n)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              wr_en,
    input  logic [n_len:0]    wr_i,
    input  logic [n_len:0]    wr_j,
    input  logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic [DATA_W-1:0] value,
    output logic              value_stb,
    input  logic              value_ack,
    output logic [n_len:0]    i,
    output logic [n_len:0]    j,
    output logic              done
);

    localparam int CELLS = n * n;
    localparam int AW    = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int IW    = n_len + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(n - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic [IW-1:0] IDX_LIM  = IW'(n);

    state_t           state_r;
    logic [CELLS-1:0] bitmap_r;
    logic [IW-1:0]    i_r;
    logic [IW-1:0]    j_r;
    logic             stb_r;
    logic             done_r;
    logic             busy_r;

    logic             wr_ok_s;
    logic [AW-1:0]    wr_addr_s;
    logic [AW-1:0]    rd_addr_s;
    logic [CELLS-1:0] set_mask_s;
    logic             fill_full_s;
    logic             ram_we_s;
    logic             ram_re_s;

    // Decode the incoming write and form the streaming read address
    always_comb begin
        wr_ok_s    = 1'b0;
        wr_addr_s  = '0;
        set_mask_s = '0;
        rd_addr_s  = AW'(int'(i_r) * n + int'(j_r));
        if (wr_en && (wr_i < IDX_LIM) && (wr_j < IDX_LIM)) begin
            wr_ok_s               = 1'b1;
            wr_addr_s             = AW'(int'(wr_i) * n + int'(wr_j));
            set_mask_s[wr_addr_s] = 1'b1;
        end else begin
            wr_ok_s = 1'b0;
        end
    end

    // A same-cycle write counts toward completion of the fill
    assign fill_full_s = &(bitmap_r | set_mask_s);
    assign ram_we_s    = wr_ok_s && (state_r == ST_FILL);
    assign ram_re_s    = (state_r == ST_LOAD);

    result_ram #(
        .DEPTH (CELLS),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (ram_we_s),
        .wr_addr (wr_addr_s),
        .wr_data (wr_data),
        .re      (ram_re_s),
        .rd_addr (rd_addr_s),
        .rd_data (value)
    );

    // Control FSM with fill bitmap, stream indices and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            bitmap_r <= '0;
            i_r      <= '0;
            j_r      <= '0;
            stb_r    <= 1'b0;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        bitmap_r <= '0;
                        state_r  <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (wr_ok_s) begin
                        bitmap_r <= bitmap_r | set_mask_s;
                        if (fill_full_s) begin
                            i_r     <= '0;
                            j_r     <= '0;
                            busy_r  <= 1'b1;
                            state_r <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    stb_r   <= 1'b1;
                    state_r <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (value_ack) begin
                        stb_r <= 1'b0;
                        if ((i_r == LAST_IDX) && (j_r == LAST_IDX)) begin
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            if (j_r == LAST_IDX) begin
                                j_r <= '0;
                                i_r <= i_r + IDX_ONE;
                            end else begin
                                j_r <= j_r + IDX_ONE;
                            end
                            state_r <= ST_LOAD;
                        end
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    stb_r   <= 1'b0;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign value_stb = stb_r;
    assign i         = i_r;
    assign j         = j_r;
    assign done      = done_r;

endmodule

// File: tb/tb_result_streamer.sv
// Self-checking bench for result_streamer (n=4): table-driven basic stream,
// directed corner cases and randomized fills checked against an array model.
module tb_result_streamer;

    localparam int N  = 4;
    localparam int IW = $clog2(N) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          wr_en = 1'b0;
    logic          value_ack = 1'b0;
    logic [IW-1:0] wr_i = '0;
    logic [IW-1:0] wr_j = '0;
    logic [31:0]   wr_data = '0;
    logic          busy, value_stb, done;
    logic [31:0]   value;
    logic [IW-1:0] i, j;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct { int r; int c; logic [31:0] d; } wr_t;
    typedef struct {
        int r; int c; logic [31:0] wdata;
        int exp_i; int exp_j; logic [31:0] exp_value;
    } vec_t;

    logic [31:0] exp_mem [N*N];
    bit          written [N*N];
    wr_t         wq[$];

    result_streamer #(.n(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .wr_en     (wr_en),
        .wr_i      (wr_i),
        .wr_j      (wr_j),
        .wr_data   (wr_data),
        .busy      (busy),
        .value     (value),
        .value_stb (value_stb),
        .value_ack (value_ack),
        .i         (i),
        .j         (j),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_value"}, value, 32'd0);
        check({tag, "_stb"}, {31'd0, value_stb}, 32'd0);
        check({tag, "_i"}, 32'(i), 32'd0);
        check({tag, "_j"}, 32'(j), 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    // Shuffled list of all in-range cells with data picked by the caller
    task automatic build_cells(input bit rand_data);
        int order[N*N];
        foreach (order[k]) order[k] = k;
        for (int k = N*N-1; k > 0; k--) begin
            int s = $urandom_range(k, 0);
            int t = order[k];
            order[k] = order[s];
            order[s] = t;
        end
        wq.delete();
        foreach (order[k]) begin
            int r = order[k] / N;
            int c = order[k] % N;
            wq.push_back('{r, c, rand_data ? 32'($urandom) : 32'(16*r + c)});
        end
    endtask

    // Pulse start, apply the write list, model the buffer and check busy after each write
    task automatic run_fill(input bit start_mid);
        int distinct = 0;
        foreach (written[k]) written[k] = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        check("fill_entry_busy", {31'd0, busy}, 32'd0);
        for (int k = 0; k < wq.size(); k++) begin
            wr_en   = 1'b1;
            wr_i    = IW'(wq[k].r);
            wr_j    = IW'(wq[k].c);
            wr_data = wq[k].d;
            if (start_mid && k == wq.size()/2) start = 1'b1;
            @(posedge clk); @(negedge clk);
            wr_en = 1'b0;
            start = 1'b0;
            if (wq[k].r < N && wq[k].c < N) begin
                if (!written[wq[k].r*N + wq[k].c]) distinct++;
                written[wq[k].r*N + wq[k].c] = 1'b1;
                exp_mem[wq[k].r*N + wq[k].c] = wq[k].d;
            end
            check("fill_busy", {31'd0, busy}, (distinct == N*N) ? 32'd1 : 32'd0);
            if (distinct == N*N) break;
        end
    endtask

    // Consume the stream (entered in LOAD) and compare with the model; optional corner-case hooks
    task automatic run_stream(input int bp_k, input int bp_len, input int wr_k,
                              input int start_k, input int rst_k);
        int c0    = cyc;
        int k     = 0;
        int guard = 0;
        int extra = 0;
        value_ack = 1'b1;
        while (k < N*N && guard < 400) begin
            @(negedge clk);
            guard++;
            wr_en = 1'b0;
            start = 1'b0;
            if (value_stb) begin
                if (k == rst_k) begin
                    rst_n = 1'b0;
                    #1;
                    check_zero_outputs("midrst");
                    value_ack = 1'b0;
                    @(negedge clk);
                    rst_n = 1'b1;
                    return;
                end
                check("stream_value", value, exp_mem[k]);
                check("stream_i", 32'(i), 32'(k / N));
                check("stream_j", 32'(j), 32'(k % N));
                if (k == wr_k || k == wr_k + 1) begin
                    wr_en   = 1'b1;
                    wr_i    = (k == wr_k) ? IW'(N-1) : IW'(0);
                    wr_j    = (k == wr_k) ? IW'(N-1) : IW'(0);
                    wr_data = 32'hFFFF_FFFF;
                end
                if (k == start_k) start = 1'b1;
                if (k == bp_k) begin
                    value_ack = 1'b0;
                    repeat (bp_len) begin
                        @(negedge clk);
                        start = 1'b0;
                        check("bp_stb", {31'd0, value_stb}, 32'd1);
                        check("bp_value", value, exp_mem[k]);
                        check("bp_ij", 32'({i, j}), 32'({IW'(k / N), IW'(k % N)}));
                    end
                    value_ack = 1'b1;
                    extra += bp_len;
                end
                k++;
            end
        end
        wr_en = 1'b0;
        start = 1'b0;
        if (k < N*N) check("stream_timeout_count", 32'(k), 32'(N*N));
        guard = 0;
        while (!done && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
        check("done_cycle", 32'(cyc - c0), 32'(2*N*N + extra));
        @(negedge clk);
        check("done_pulse_end", {31'd0, done}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
        value_ack = 1'b0;
    endtask

    initial begin
        vec_t tbl[N*N];

        // Expected stream: row r, column c carries 16r+c
        for (int k = 0; k < N*N; k++) begin
            tbl[k] = '{k / N, k % N, 32'(16*(k/N) + k%N), k / N, k % N, 32'(16*(k/N) + k%N)};
        end

        // Reset state
        @(negedge clk);
        check_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic stream: table writes in random order, ack tied high
        build_cells(1'b0);
        foreach (wq[k]) wq[k].d = tbl[wq[k].r*N + wq[k].c].wdata;
        run_fill(1'b0);
        foreach (tbl[k]) exp_mem[tbl[k].exp_i*N + tbl[k].exp_j] = tbl[k].exp_value;
        run_stream(-1, 0, -1, -1, -1);

        // Backpressure on (1,2), start ignored during FILL and STREAM
        build_cells(1'b0);
        run_fill(1'b1);
        run_stream(1*N + 2, 5, -1, 10, -1);

        // Duplicate and out-of-range writes, then writes while streaming
        build_cells(1'b0);
        for (int k = 0; k < wq.size(); k++) begin
            if (wq[k].r == 0 && wq[k].c == 0) begin
                wq.delete(k);
                break;
            end
        end
        wq.push_front('{N, 0, 32'hDEAD});
        wq.push_front('{0, 0, 32'hBBBB});
        wq.push_front('{0, 0, 32'hAAAA});
        run_fill(1'b0);
        check("dup_model_00", exp_mem[0], 32'hBBBB);
        run_stream(-1, 0, 1, -1, -1);

        // Reset at element (2,1), then a fresh full run
        build_cells(1'b1);
        run_fill(1'b0);
        run_stream(-1, 0, -1, -1, 2*N + 1);
        check_zero_outputs("after_midrst");
        build_cells(1'b1);
        run_fill(1'b0);
        run_stream(-1, 0, -1, -1, -1);

        // Randomized fills with duplicates, out-of-range writes and a random stall
        for (int run = 0; run < 4; run++) begin
            build_cells(1'b1);
            repeat ($urandom_range(4, 0)) begin
                wq.insert($urandom_range(wq.size() - 1, 0),
                          '{$urandom_range(N-1, 0), $urandom_range(N-1, 0), 32'($urandom)});
            end
            repeat ($urandom_range(3, 0)) begin
                if ($urandom_range(1, 0) == 1)
                    wq.insert($urandom_range(wq.size() - 1, 0),
                              '{$urandom_range((1 << IW) - 1, N), $urandom_range(N-1, 0), 32'($urandom)});
                else
                    wq.insert($urandom_range(wq.size() - 1, 0),
                              '{$urandom_range(N-1, 0), $urandom_range((1 << IW) - 1, N), 32'($urandom)});
            end
            run_fill(1'b0);
            run_stream($urandom_range(N*N - 1, 0), $urandom_range(6, 1), -1, -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
